ula_op_sequencer: RTL and testbench

Multicycle controller that sequences the RegisterFile + ula datapath: accepts one ALU command per valid/ready handshake, then reads operands, executes, writes back, and reports the result.
Replaces hand-driven switch/KEY control of the datapath and is the step toward the CPU control path.
Instantiates neither the register file nor the ALU; it drives their ports and samples their outputs.

---
 rtl/ula_op_sequencer.sv | 146 ++++++++++++++
 tb/tb_ula_op_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ula_op_sequencer.sv
// Multicycle controller for the RegisterFile + ula datapath: one ALU command per
// handshake, sequenced through operand read, execute, write-back and completion.
module ula_op_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic [ADDR_W-1:0] cmd_rs1,
  input  logic [ADDR_W-1:0] cmd_rs2,
  input  logic              cmd_use_imm,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [ADDR_W-1:0] rf_ra1,
  output logic [ADDR_W-1:0] rf_ra2,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  output logic              rf_we3,
  output logic [ADDR_W-1:0] rf_wa3,
  output logic [DATA_W-1:0] rf_wd3,
  output logic [DATA_W-1:0] alu_srca,
  output logic [DATA_W-1:0] alu_srcb,
  output logic [2:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_z,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic [7:0]        op_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_EXEC  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [2:0]          r_op;
  logic [ADDR_W-1:0]   r_rd;
  logic [ADDR_W-1:0]   r_rs1;
  logic [ADDR_W-1:0]   r_rs2;
  logic                r_use_imm;
  logic [DATA_W-1:0]   r_imm;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [DATA_W-1:0]   r_res;
  logic                r_z;
  logic                r_err;
  logic [DATA_W-1:0]   r_result;
  logic                r_zero;
  logic [7:0]          r_op_count;
  logic                w_hs;
  logic                w_illegal;

  // Ready is held low while reset is asserted even though the state is already IDLE.
  assign cmd_ready = (r_state == S_IDLE) && rst_n;
  assign w_hs      = cmd_valid && cmd_ready;
  assign w_illegal = (r_op == 3'b011) || (r_op == 3'b100) || (r_op == 3'b101);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_hs) w_next = S_READ;
      S_READ:  w_next = S_EXEC;
      S_EXEC:  w_next = w_illegal ? S_DONE : S_WRITE;
      S_WRITE: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_op       <= '0;
      r_rd       <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_use_imm  <= 1'b0;
      r_imm      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_res      <= '0;
      r_z        <= 1'b0;
      r_err      <= 1'b0;
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_op_count <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            r_op      <= cmd_op;
            r_rd      <= cmd_rd;
            r_rs1     <= cmd_rs1;
            r_rs2     <= cmd_rs2;
            r_use_imm <= cmd_use_imm;
            r_imm     <= cmd_imm;
          end
        end
        S_READ: begin
          r_a <= rf_rd1;
          r_b <= r_use_imm ? r_imm : rf_rd2;
        end
        S_EXEC: begin
          r_res <= alu_result;
          r_z   <= alu_z;
          r_err <= w_illegal;
        end
        S_DONE: begin
          // Illegal commands complete without disturbing the reported status.
          if (!r_err) begin
            r_result   <= r_res;
            r_zero     <= r_z;
            r_op_count <= r_op_count + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rf_ra1   = (r_state == S_READ)  ? r_rs1 : '0;
  assign rf_ra2   = (r_state == S_READ)  ? r_rs2 : '0;
  assign rf_we3   = (r_state == S_WRITE);
  assign rf_wa3   = (r_state == S_WRITE) ? r_rd  : '0;
  assign rf_wd3   = (r_state == S_WRITE) ? r_res : '0;
  assign alu_srca = r_a;
  assign alu_srcb = r_b;
  assign alu_ctrl = r_op;
  assign done     = (r_state == S_DONE);
  assign err      = (r_state == S_DONE) && r_err;
  assign result   = r_result;
  assign zero     = r_zero;
  assign op_count = r_op_count;

endmodule

// File: tb/tb_ula_op_sequencer.sv
// Directed bench for ula_op_sequencer with a behavioural register file and ALU
// attached to its datapath ports.
module tb_ula_op_sequencer;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [2:0]        cmd_op = '0;
  logic [ADDR_W-1:0] cmd_rd = '0;
  logic [ADDR_W-1:0] cmd_rs1 = '0;
  logic [ADDR_W-1:0] cmd_rs2 = '0;
  logic              cmd_use_imm = 1'b0;
  logic [DATA_W-1:0] cmd_imm = '0;
  logic [ADDR_W-1:0] rf_ra1, rf_ra2, rf_wa3;
  logic [DATA_W-1:0] rf_rd1, rf_rd2, rf_wd3;
  logic              rf_we3;
  logic [DATA_W-1:0] alu_srca, alu_srcb, alu_result;
  logic [2:0]        alu_ctrl;
  logic              alu_z;
  logic              done, err, zero;
  logic [DATA_W-1:0] result;
  logic [7:0]        op_count;

  logic [DATA_W-1:0] rf [8];
  logic              tb_we = 1'b0;
  logic [ADDR_W-1:0] tb_wa = '0;
  logic [DATA_W-1:0] tb_wd = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ula_op_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .cmd_use_imm(cmd_use_imm), .cmd_imm(cmd_imm),
    .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .rf_we3(rf_we3), .rf_wa3(rf_wa3), .rf_wd3(rf_wd3),
    .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_z(alu_z),
    .done(done), .err(err), .result(result), .zero(zero), .op_count(op_count)
  );

  // Register file model: combinational read, write on the rising edge.
  always @(posedge clk) begin
    if (tb_we) rf[tb_wa] <= tb_wd;
    else if (rf_we3) rf[rf_wa3] <= rf_wd3;
  end
  assign rf_rd1 = rf[rf_ra1];
  assign rf_rd2 = rf[rf_ra2];

  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      3'b000: alu_result = alu_srca & alu_srcb;
      3'b001: alu_result = alu_srca | alu_srcb;
      3'b010: alu_result = alu_srca + alu_srcb;
      3'b110: alu_result = alu_srca - alu_srcb;
      3'b111: alu_result = ($signed(alu_srca) < $signed(alu_srcb)) ? 8'd1 : 8'd0;
      default: alu_result = '0;
    endcase
  end
  assign alu_z = (alu_result == '0);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    tb_we = 1'b1; tb_wa = a; tb_wd = d;
    step();
    tb_we = 1'b0;
  endtask

  // Presents one command for the handshake edge; returns in READ.
  task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic use_imm, input logic [7:0] imm);
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
    cmd_use_imm = use_imm; cmd_imm = imm;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [63:0] outs;
    for (int i = 0; i < 8; i++) rf[i] = '0;
    rst_n = 1'b0;
    step();
    outs = {done, err, result, zero, op_count, rf_ra1, rf_ra2, rf_we3, rf_wa3, rf_wd3,
            alu_srca, alu_srcb, alu_ctrl};
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0b exp=0", cmd_ready); end
    checks++; if (outs !== 64'd0) begin failures++; $display("FAIL reset_outs got=%0h exp=0", outs); end
    #2 rst_n = 1'b1;
    step();
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL release_ready got=%0b exp=1", cmd_ready); end
    checks++; if (op_count !== 8'd0) begin failures++; $display("FAIL release_count got=%0d exp=0", op_count); end
  endtask

  task automatic test_imm_add();
    poke(3'd1, 8'd5);
    issue(3'b010, 3'd2, 3'd1, 3'd0, 1'b1, 8'd3);
    checks++; if (rf_ra1 !== 3'd1 || cmd_ready !== 1'b0) begin failures++; $display("FAIL add_read ra1=%0d ready=%0b exp ra1=1 ready=0", rf_ra1, cmd_ready); end
    step();
    checks++; if ({alu_srca, alu_srcb, alu_ctrl} !== {8'd5, 8'd3, 3'b010}) begin failures++; $display("FAIL add_exec a=%0d b=%0d ctrl=%0b exp 5 3 010", alu_srca, alu_srcb, alu_ctrl); end
    step();
    checks++; if ({rf_we3, rf_wa3, rf_wd3} !== {1'b1, 3'd2, 8'd8}) begin failures++; $display("FAIL add_write we=%0b wa=%0d wd=%0d exp 1 2 8", rf_we3, rf_wa3, rf_wd3); end
    step();
    checks++; if ({done, err, rf_we3} !== 3'b100 || rf[2] !== 8'd8) begin failures++; $display("FAIL add_done done=%0b err=%0b we=%0b r2=%0d exp 1 0 0 8", done, err, rf_we3, rf[2]); end
    step();
    checks++; if ({cmd_ready, done, result, zero, op_count} !== {1'b1, 1'b0, 8'd8, 1'b0, 8'd1}) begin failures++; $display("FAIL add_status ready=%0b done=%0b res=%0d z=%0b cnt=%0d exp 1 0 8 0 1", cmd_ready, done, result, zero, op_count); end
  endtask

  task automatic test_sub_zero_raw();
    poke(3'd3, 8'd8);
    poke(3'd4, 8'h55);
    issue(3'b110, 3'd4, 3'd2, 3'd3, 1'b0, 8'hff);
    checks++; if (rf_ra2 !== 3'd3) begin failures++; $display("FAIL sub_ra2 got=%0d exp=3", rf_ra2); end
    repeat (4) step();
    checks++; if ({rf[4], result, zero, op_count} !== {8'd0, 8'd0, 1'b1, 8'd2}) begin failures++; $display("FAIL sub_zero r4=%0d res=%0d z=%0b cnt=%0d exp 0 0 1 2", rf[4], result, zero, op_count); end
    issue(3'b010, 3'd5, 3'd4, 3'd0, 1'b1, 8'd1);
    repeat (4) step();
    checks++; if ({rf[5], result, zero, op_count} !== {8'd1, 8'd1, 1'b0, 8'd3}) begin failures++; $display("FAIL raw r5=%0d res=%0d z=%0b cnt=%0d exp 1 1 0 3", rf[5], result, zero, op_count); end
  endtask

  task automatic test_illegal();
    logic we_seen;
    poke(3'd6, 8'h77);
    issue(3'b101, 3'd6, 3'd1, 3'd2, 1'b0, 8'd0);
    we_seen = rf_we3;
    step();
    we_seen = we_seen | rf_we3;
    step();
    we_seen = we_seen | rf_we3;
    checks++; if ({done, err} !== 2'b11) begin failures++; $display("FAIL illegal_done done=%0b err=%0b exp 1 1", done, err); end
    step();
    checks++; if (we_seen !== 1'b0 || rf[6] !== 8'h77) begin failures++; $display("FAIL illegal_nowrite we_seen=%0b r6=%0h exp 0 77", we_seen, rf[6]); end
    checks++; if ({cmd_ready, done, err, result, zero, op_count} !== {3'b100, 8'd1, 1'b0, 8'd3}) begin failures++; $display("FAIL illegal_status ready=%0b done=%0b err=%0b res=%0d z=%0b cnt=%0d exp 1 0 0 1 0 3", cmd_ready, done, err, result, zero, op_count); end
  endtask

  task automatic test_back_to_back();
    int hs = 0;
    int dn = 0;
    cmd_valid = 1'b1; cmd_op = 3'b010; cmd_rd = 3'd7; cmd_rs1 = 3'd1; cmd_use_imm = 1'b1; cmd_imm = 8'd1;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready) hs++;
      if (done) dn++;
      step();
    end
    cmd_valid = 1'b0;
    checks++; if (hs !== 4 || dn !== 4) begin failures++; $display("FAIL held_valid handshakes=%0d dones=%0d exp 4 4", hs, dn); end
    checks++; if (op_count !== 8'd7 || rf[7] !== 8'd6) begin failures++; $display("FAIL held_count cnt=%0d r7=%0d exp 7 6", op_count, rf[7]); end
  endtask

  task automatic test_midop_reset();
    int dn = 0;
    issue(3'b010, 3'd3, 3'd1, 3'd0, 1'b1, 8'd10);
    step();
    step();
    checks++; if (rf_we3 !== 1'b1) begin failures++; $display("FAIL midrst_write we=%0b exp=1", rf_we3); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rf_we3 !== 1'b0) begin failures++; $display("FAIL midrst_async_we got=%0b exp=0", rf_we3); end
    step();
    if (done) dn++;
    checks++; if (rf[3] !== 8'd8) begin failures++; $display("FAIL midrst_rf got=%0d exp=8", rf[3]); end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (done) dn++;
    end
    checks++; if (dn !== 0 || cmd_ready !== 1'b1 || op_count !== 8'd0) begin failures++; $display("FAIL midrst_after dones=%0d ready=%0b cnt=%0d exp 0 1 0", dn, cmd_ready, op_count); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 256; i++) begin
      issue(3'b010, 3'd0, 3'd1, 3'd0, 1'b1, 8'd0);
      repeat (4) step();
      if (i == 254) begin
        checks++; if (op_count !== 8'd255) begin failures++; $display("FAIL wrap_255 got=%0d exp=255", op_count); end
      end
    end
    checks++; if (op_count !== 8'd0 || result !== 8'd5) begin failures++; $display("FAIL wrap_0 cnt=%0d res=%0d exp 0 5", op_count, result); end
  endtask

  initial begin
    test_reset();
    test_imm_add();
    test_sub_zero_raw();
    test_illegal();
    test_back_to_back();
    test_midop_reset();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
